// File: rtl/game_referee_pkg.sv
// game_referee_pkg: shared match-state encoding and playfield geometry for the volleyball game
package game_referee_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        DROP    = 2'd1,
        IN_GAME = 2'd2,
        END     = 2'd3
    } game_state_e;

    localparam int VBUF_W    = 320;
    localparam int VBUF_H    = 240;
    localparam int NET_POS_X = 160;
    localparam int NET_W     = 6;
    localparam int BALL_W    = 30;
    localparam int BALL_H    = 30;
    localparam int FLOOR_Y   = 220;

endpackage

// File: rtl/game_referee_score_counter.sv
// score_counter: 4-bit saturating point counter that flags when the next point wins
module score_counter #(
    parameter int WIN_SCORE = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] score,
    output logic       win_on_inc
);
    logic [3:0] score_q, score_d;

    // clear wins over increment; the count never moves past the winning score
    always_comb begin
        score_d = clr ? 4'd0 : (inc && score_q != 4'(WIN_SCORE)) ? score_q + 4'd1 : score_q;
    end

    // score register
    always_ff @(posedge clk) begin
        if (!reset_n) score_q <= 4'd0;
        else          score_q <= score_d;
    end

    assign score      = score_q;
    assign win_on_inc = (score_q == 4'(WIN_SCORE - 1));
endmodule

// File: rtl/game_referee.sv
// game_referee: rally referee and match FSM; detects floor contact, scores points, sequences rallies
module game_referee
    import game_referee_pkg::*;
#(
    parameter int GROUND_Y       = 190,
    parameter int BALL_W         = 30,
    parameter int NET_CENTER_X   = 163,
    parameter int PLAYER_ON_LEFT = 1,
    parameter int WIN_SCORE      = 15,
    parameter int DROP_CYCLES    = 100_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    output logic [1:0]  game_state,
    output logic        who_win,
    output logic [3:0]  player_score,
    output logic [3:0]  npc_score,
    output logic        point_pulse
);
    localparam int CW = (DROP_CYCLES > 2) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DROP_CYCLES - 1);

    game_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          who_q, who_d;
    logic          pulse_q, pulse_d;
    logic          inc_p, inc_n, clr;
    logic          p_win_next, n_win_next;
    logic [12:0]   centre;
    logic          left_side, npc_scores, ground_hit, match_over;

    // landing side decode: centre on the net line counts as the right side
    always_comb begin
        centre     = {1'b0, ball_x} + 13'(BALL_W / 2);
        left_side  = centre < 13'(NET_CENTER_X);
        npc_scores = (left_side == (PLAYER_ON_LEFT != 0));
        ground_hit = armed_q && (ball_y >= 12'(GROUND_Y));
        match_over = npc_scores ? n_win_next : p_win_next;
    end

    // next-state logic for the match FSM, drop timer and rally bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        who_d   = who_q;
        pulse_d = 1'b0;
        inc_p   = 1'b0;
        inc_n   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            START: begin
                if (start_btn) begin
                    state_d = DROP;
                    cnt_d   = '0;
                end
            end
            DROP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IN_GAME;
                    armed_d = 1'b0;
                end
            end
            IN_GAME: begin
                armed_d = 1'b1;
                if (ground_hit) begin
                    inc_p   = !npc_scores;
                    inc_n   = npc_scores;
                    who_d   = npc_scores;
                    pulse_d = 1'b1;
                    state_d = match_over ? END : DROP;
                    cnt_d   = '0;
                end
            end
            END: begin
                if (start_btn) begin
                    clr     = 1'b1;
                    who_d   = 1'b0;
                    state_d = DROP;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // match state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= START;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            who_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            who_q   <= who_d;
            pulse_q <= pulse_d;
        end
    end

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_player (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (inc_p),
        .clr        (clr),
        .score      (player_score),
        .win_on_inc (p_win_next)
    );

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_npc (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (inc_n),
        .clr        (clr),
        .score      (npc_score),
        .win_on_inc (n_win_next)
    );

    assign game_state  = state_q;
    assign who_win     = who_q;
    assign point_pulse = pulse_q;
endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: directed scenario bench for the rally referee
module tb_game_referee;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_btn = 1'b0;
    logic [11:0] ball_x = 12'd0;
    logic [11:0] ball_y = 12'd0;
    logic [1:0]  game_state;
    logic        who_win;
    logic [3:0]  player_score;
    logic [3:0]  npc_score;
    logic        point_pulse;
    logic [11:0] obs;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    game_referee #(.DROP_CYCLES(4), .WIN_SCORE(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .game_state   (game_state),
        .who_win      (who_win),
        .player_score (player_score),
        .npc_score    (npc_score),
        .point_pulse  (point_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {game_state, who_win, player_score, npc_score, point_pulse};

    function automatic logic [11:0] ex(input int st, input int who, input int p, input int n, input int pl);
        return {2'(st), 1'(who), 4'(p), 4'(n), 1'(pl)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_in_game();
        for (int i = 0; i < 20 && game_state != 2'd2; i++) step();
        total_cnt++;
        if (game_state !== 2'd2) $display("FAIL wait_in_game: state=%0d required 2", game_state);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        total_cnt++;
        if (obs !== ex(0, 0, 0, 0, 0)) $display("FAIL reset: got %h required %h", obs, ex(0, 0, 0, 0, 0));
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== ex(0, 0, 0, 0, 0)) $display("FAIL idle_start: got %h required %h", obs, ex(0, 0, 0, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_start_drop();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        total_cnt++;
        if (obs !== ex(1, 0, 0, 0, 0)) $display("FAIL start_to_drop: got %h required %h", obs, ex(1, 0, 0, 0, 0));
        else pass_cnt++;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        step();
        total_cnt++;
        if (obs !== ex(1, 0, 0, 0, 0)) $display("FAIL drop_dwell_3: got %h required %h", obs, ex(1, 0, 0, 0, 0));
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== ex(2, 0, 0, 0, 0)) $display("FAIL drop_dwell_4: got %h required %h", obs, ex(2, 0, 0, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_npc_point();
        step();
        ball_x = 12'd40;
        ball_y = 12'd190;
        step();
        total_cnt++;
        if (obs !== ex(1, 1, 0, 1, 1)) $display("FAIL npc_point: got %h required %h", obs, ex(1, 1, 0, 1, 1));
        else pass_cnt++;
        ball_y = 12'd0;
        step();
        total_cnt++;
        if (obs !== ex(1, 1, 0, 1, 0)) $display("FAIL pulse_one_cycle: got %h required %h", obs, ex(1, 1, 0, 1, 0));
        else pass_cnt++;
    endtask

    task automatic test_side_boundary();
        wait_in_game();
        step();
        ball_x = 12'd133;
        ball_y = 12'd190;
        step();
        ball_y = 12'd0;
        total_cnt++;
        if (obs !== ex(1, 1, 0, 2, 1)) $display("FAIL centre_148_left: got %h required %h", obs, ex(1, 1, 0, 2, 1));
        else pass_cnt++;
        wait_in_game();
        step();
        ball_x = 12'd148;
        ball_y = 12'd190;
        step();
        total_cnt++;
        if (obs !== ex(1, 0, 1, 2, 1)) $display("FAIL centre_163_right: got %h required %h", obs, ex(1, 0, 1, 2, 1));
        else pass_cnt++;
    endtask

    task automatic test_arm_mask();
        ball_x = 12'd200;
        ball_y = 12'd200;
        wait_in_game();
        step();
        total_cnt++;
        if (obs !== ex(2, 0, 1, 2, 0)) $display("FAIL mask_first_cycle: got %h required %h", obs, ex(2, 0, 1, 2, 0));
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== ex(1, 0, 2, 2, 1)) $display("FAIL armed_second_cycle: got %h required %h", obs, ex(1, 0, 2, 2, 1));
        else pass_cnt++;
    endtask

    task automatic test_match_end();
        wait_in_game();
        step();
        step();
        total_cnt++;
        if (obs !== ex(3, 0, 3, 2, 1)) $display("FAIL win_to_end: got %h required %h", obs, ex(3, 0, 3, 2, 1));
        else pass_cnt++;
        ball_x = 12'd40;
        step();
        step();
        step();
        total_cnt++;
        if (obs !== ex(3, 0, 3, 2, 0)) $display("FAIL end_holds: got %h required %h", obs, ex(3, 0, 3, 2, 0));
        else pass_cnt++;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        total_cnt++;
        if (obs !== ex(1, 0, 0, 0, 0)) $display("FAIL restart_clears: got %h required %h", obs, ex(1, 0, 0, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drop();
        ball_y = 12'd200;
        ball_x = 12'd200;
        wait_in_game();
        step();
        step();
        wait_in_game();
        step();
        step();
        ball_x = 12'd40;
        wait_in_game();
        step();
        step();
        step();
        total_cnt++;
        if (obs !== ex(1, 1, 2, 1, 0)) $display("FAIL pre_reset_scores: got %h required %h", obs, ex(1, 1, 2, 1, 0));
        else pass_cnt++;
        reset_n = 1'b0;
        step();
        total_cnt++;
        if (obs !== ex(0, 0, 0, 0, 0)) $display("FAIL reset_mid_drop: got %h required %h", obs, ex(0, 0, 0, 0, 0));
        else pass_cnt++;
        reset_n = 1'b1;
        step();
        step();
        step();
        step();
        step();
        total_cnt++;
        if (obs !== ex(0, 0, 0, 0, 0)) $display("FAIL stays_start: got %h required %h", obs, ex(0, 0, 0, 0, 0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start_drop();
        test_npc_point();
        test_side_boundary();
        test_arm_mask();
        test_match_end();
        test_reset_mid_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
